// File: rtl/bellek_pkg.sv
// Shared definitions for the load/store unit and the memory block:
// RISC-V funct3 access types and the controller state encoding.
package bellek_pkg;

    localparam logic [2:0] TUR_B  = 3'b000;
    localparam logic [2:0] TUR_H  = 3'b001;
    localparam logic [2:0] TUR_W  = 3'b010;
    localparam logic [2:0] TUR_BU = 3'b100;
    localparam logic [2:0] TUR_HU = 3'b101;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        OKU   = 2'd1,
        YAZ   = 2'd2,
        YANIT = 2'd3
    } durum_t;

    function automatic logic tur_gecerli(input logic [2:0] tur);
        return (tur == TUR_B) || (tur == TUR_H) || (tur == TUR_W) ||
               (tur == TUR_BU) || (tur == TUR_HU);
    endfunction

endpackage

// File: rtl/bayt_hizalayici.sv
// Byte/halfword lane handling: extracts and extends load data from a memory
// word, and merges right-aligned store data into the addressed lane.
module bayt_hizalayici
    import bellek_pkg::*;
(
    input  logic [31:0] kelime,
    input  logic [1:0]  adres,
    input  logic [2:0]  tur,
    input  logic [31:0] yaz_veri,
    output logic [31:0] yuk_veri,
    output logic [31:0] birlesik_veri
);

    logic [7:0]  bayt;
    logic [15:0] yarim;

    assign bayt  = kelime[8*adres +: 8];
    assign yarim = adres[1] ? kelime[31:16] : kelime[15:0];

    always_comb begin
        yuk_veri = kelime;
        case (tur)
            TUR_B:   yuk_veri = {{24{bayt[7]}}, bayt};
            TUR_BU:  yuk_veri = {24'd0, bayt};
            TUR_H:   yuk_veri = {{16{yarim[15]}}, yarim};
            TUR_HU:  yuk_veri = {16'd0, yarim};
            default: yuk_veri = kelime;
        endcase
    end

    // Only the addressed lane is replaced; the rest comes from the read word.
    always_comb begin
        birlesik_veri = yaz_veri;
        case (tur)
            TUR_B: begin
                birlesik_veri = kelime;
                birlesik_veri[8*adres +: 8] = yaz_veri[7:0];
            end
            TUR_H: begin
                birlesik_veri = kelime;
                if (adres[1]) birlesik_veri[31:16] = yaz_veri[15:0];
                else          birlesik_veri[15:0]  = yaz_veri[15:0];
            end
            default: birlesik_veri = yaz_veri;
        endcase
    end

endmodule

// File: rtl/bellek_erisim_birimi.sv
// Load/store initiator: one request at a time, alignment/range checking,
// read-modify-write for sub-word stores, extended load data on the response.
module bellek_erisim_birimi
    import bellek_pkg::*;
#(
    parameter int                  ADRES_BIT       = 32,
    parameter int                  VERI_BIT        = 32,
    parameter logic [ADRES_BIT-1:0] BASLANGIC_ADRES = 32'h8000_0000,
    parameter int                  BELLEK_BOYUT    = 2048
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 istek_gecerli,
    output logic                 istek_hazir,
    input  logic [ADRES_BIT-1:0] istek_adres,
    input  logic                 istek_yaz,
    input  logic [2:0]           istek_tur,
    input  logic [VERI_BIT-1:0]  istek_veri,
    output logic                 yanit_gecerli,
    input  logic                 yanit_hazir,
    output logic [VERI_BIT-1:0]  yanit_veri,
    output logic                 yanit_hata,
    output logic [ADRES_BIT-1:0] bellek_adres,
    input  logic [VERI_BIT-1:0]  bellek_oku_veri,
    output logic [VERI_BIT-1:0]  bellek_yaz_veri,
    output logic                 bellek_yaz_gecerli
);

    // One extra bit so BASLANGIC_ADRES+BELLEK_BOYUT cannot wrap to zero.
    localparam logic [ADRES_BIT:0] ALT = {1'b0, BASLANGIC_ADRES};
    localparam logic [ADRES_BIT:0] UST = ALT + (ADRES_BIT+1)'(BELLEK_BOYUT);

    durum_t durum, durum_sonraki;

    logic [1:0]          adres_q;
    logic                yaz_q;
    logic [2:0]          tur_q;
    logic [VERI_BIT-1:0] veri_q;
    logic [VERI_BIT-1:0] yanit_veri_q;
    logic                yanit_hata_q;
    logic [ADRES_BIT-1:0] bellek_adres_q;
    logic [VERI_BIT-1:0] bellek_yaz_veri_q;

    logic [ADRES_BIT:0]  adres_g;
    logic                hizalama_hata, aralik_hata, tur_hata, hata_c, kabul;
    logic [VERI_BIT-1:0] yuk_veri, birlesik_veri;

    assign adres_g       = {1'b0, istek_adres};
    assign aralik_hata   = (adres_g < ALT) || (adres_g >= UST);
    assign hizalama_hata = (((istek_tur == TUR_H) || (istek_tur == TUR_HU)) && istek_adres[0]) ||
                           ((istek_tur == TUR_W) && (istek_adres[1:0] != 2'b00));
    assign tur_hata      = !tur_gecerli(istek_tur) ||
                           (istek_yaz && ((istek_tur == TUR_BU) || (istek_tur == TUR_HU)));
    assign hata_c        = hizalama_hata || aralik_hata || tur_hata;
    assign kabul         = istek_gecerli && istek_hazir;

    bayt_hizalayici u_hizalayici (
        .kelime        (bellek_oku_veri),
        .adres         (adres_q),
        .tur           (tur_q),
        .yaz_veri      (veri_q),
        .yuk_veri      (yuk_veri),
        .birlesik_veri (birlesik_veri)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) durum <= BOSTA;
        else        durum <= durum_sonraki;
    end

    always_comb begin
        durum_sonraki = durum;
        case (durum)
            BOSTA: if (kabul) begin
                if (hata_c)                                 durum_sonraki = YANIT;
                else if (istek_yaz && (istek_tur == TUR_W)) durum_sonraki = YAZ;
                else                                        durum_sonraki = OKU;
            end
            OKU:     durum_sonraki = yaz_q ? YAZ : YANIT;
            YAZ:     durum_sonraki = YANIT;
            YANIT:   if (yanit_hazir) durum_sonraki = BOSTA;
            default: durum_sonraki = BOSTA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adres_q           <= '0;
            yaz_q             <= 1'b0;
            tur_q             <= '0;
            veri_q            <= '0;
            yanit_veri_q      <= '0;
            yanit_hata_q      <= 1'b0;
            bellek_adres_q    <= '0;
            bellek_yaz_veri_q <= '0;
        end else begin
            case (durum)
                BOSTA: if (kabul) begin
                    adres_q      <= istek_adres[1:0];
                    yaz_q        <= istek_yaz;
                    tur_q        <= istek_tur;
                    veri_q       <= istek_veri;
                    yanit_veri_q <= '0;
                    yanit_hata_q <= hata_c;
                    // Memory-side outputs move only for accesses that go to memory.
                    if (!hata_c)
                        bellek_adres_q <= {istek_adres[ADRES_BIT-1:2], 2'b00};
                    if (!hata_c && istek_yaz && (istek_tur == TUR_W))
                        bellek_yaz_veri_q <= istek_veri;
                end
                OKU: begin
                    if (yaz_q) bellek_yaz_veri_q <= birlesik_veri;
                    else       yanit_veri_q      <= yuk_veri;
                end
                default: ;
            endcase
        end
    end

    assign istek_hazir        = (durum == BOSTA);
    assign yanit_gecerli      = (durum == YANIT);
    assign yanit_veri         = yanit_veri_q;
    assign yanit_hata         = yanit_hata_q;
    assign bellek_adres       = bellek_adres_q;
    assign bellek_yaz_veri    = bellek_yaz_veri_q;
    // rst_n gating keeps a write from slipping through on the edge reset lands.
    assign bellek_yaz_gecerli = (durum == YAZ) && rst_n;

endmodule

// File: tb/tb_bellek_erisim_birimi.sv
// Directed bench for bellek_erisim_birimi with a word-organised memory model.
module tb_bellek_erisim_birimi;
    import bellek_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        istek_gecerli, istek_hazir, istek_yaz;
    logic [31:0] istek_adres, istek_veri;
    logic [2:0]  istek_tur;
    logic        yanit_gecerli, yanit_hazir, yanit_hata;
    logic [31:0] yanit_veri;
    logic [31:0] bellek_adres, bellek_oku_veri, bellek_yaz_veri;
    logic        bellek_yaz_gecerli;

    logic [31:0] mem [0:511];
    int          yaz_sayisi;
    logic [31:0] son_yaz;
    int          kontroller = 0;
    int          hatalar    = 0;

    always #5 clk = ~clk;

    bellek_erisim_birimi dut (
        .clk(clk), .rst_n(rst_n),
        .istek_gecerli(istek_gecerli), .istek_hazir(istek_hazir),
        .istek_adres(istek_adres), .istek_yaz(istek_yaz),
        .istek_tur(istek_tur), .istek_veri(istek_veri),
        .yanit_gecerli(yanit_gecerli), .yanit_hazir(yanit_hazir),
        .yanit_veri(yanit_veri), .yanit_hata(yanit_hata),
        .bellek_adres(bellek_adres), .bellek_oku_veri(bellek_oku_veri),
        .bellek_yaz_veri(bellek_yaz_veri), .bellek_yaz_gecerli(bellek_yaz_gecerli)
    );

    assign bellek_oku_veri = mem[bellek_adres[10:2]];

    always @(posedge clk) begin
        if (bellek_yaz_gecerli) begin
            mem[bellek_adres[10:2]] <= bellek_yaz_veri;
            son_yaz    <= bellek_yaz_veri;
            yaz_sayisi <= yaz_sayisi + 1;
        end
    end

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        kontroller++;
        if (gozlenen !== beklenen) begin
            hatalar++;
            $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
        end
    endtask

    // Issues one request with yanit_hazir=1; gecikme counts cycles from accept
    // edge until yanit_gecerli is seen (-1 if it never arrives).
    task automatic islem(input logic yaz, input logic [2:0] tur, input logic [31:0] adr,
                         input logic [31:0] veri, output logic [31:0] rv, output logic rh,
                         output int gecikme);
        @(negedge clk);
        istek_gecerli = 1'b1; istek_yaz = yaz; istek_tur = tur;
        istek_adres = adr; istek_veri = veri; yanit_hazir = 1'b1;
        @(posedge clk); #1;
        istek_gecerli = 1'b0;
        gecikme = -1; rv = 'x; rh = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            if (yanit_gecerli) begin
                gecikme = k; rv = yanit_veri; rh = yanit_hata;
                break;
            end
            @(posedge clk); #1;
        end
        if (gecikme > 0) begin
            @(posedge clk); #1;
        end
    endtask

    logic [31:0] rv;
    logic        rh;
    int          gec;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        yaz_sayisi = 0; son_yaz = 0;
        istek_gecerli = 1'b0; istek_yaz = 1'b0; istek_tur = TUR_W;
        istek_adres = 0; istek_veri = 0; yanit_hazir = 1'b1;
        rst_n = 1'b0;
        #2 istek_gecerli = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        kontrol("reset istek_hazir", 32'(istek_hazir), 32'd1);
        kontrol("reset yanit_gecerli", 32'(yanit_gecerli), 32'd0);
        kontrol("reset yanit_veri", yanit_veri, 32'd0);
        kontrol("reset yanit_hata", 32'(yanit_hata), 32'd0);
        kontrol("reset bellek_adres", bellek_adres, 32'd0);
        kontrol("reset yaz_veri", bellek_yaz_veri, 32'd0);
        kontrol("reset yaz_gecerli", 32'(bellek_yaz_gecerli), 32'd0);
        istek_gecerli = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        mem[1] = 32'hDEAD_BEEF;
        islem(1'b0, TUR_W, 32'h8000_0004, 0, rv, rh, gec);
        kontrol("LW veri", rv, 32'hDEAD_BEEF);
        kontrol("LW hata", 32'(rh), 32'd0);
        kontrol("LW gecikme", 32'(gec), 32'd2);

        mem[1] = 32'h80FF_0102;
        islem(1'b0, TUR_B, 32'h8000_0007, 0, rv, rh, gec);
        kontrol("LB veri", rv, 32'hFFFF_FF80);
        islem(1'b0, TUR_BU, 32'h8000_0007, 0, rv, rh, gec);
        kontrol("LBU veri", rv, 32'h0000_0080);
        islem(1'b0, TUR_H, 32'h8000_0006, 0, rv, rh, gec);
        kontrol("LH veri", rv, 32'hFFFF_80FF);
        islem(1'b0, TUR_HU, 32'h8000_0004, 0, rv, rh, gec);
        kontrol("LHU veri", rv, 32'h0000_0102);

        mem[2] = 32'h1122_3344;
        yaz_sayisi = 0;
        islem(1'b1, TUR_B, 32'h8000_0009, 32'h0000_00AA, rv, rh, gec);
        kontrol("SB gecikme", 32'(gec), 32'd3);
        kontrol("SB yaz sayisi", 32'(yaz_sayisi), 32'd1);
        kontrol("SB yazilan", son_yaz, 32'h1122_AA44);
        kontrol("SB yanit_veri", rv, 32'd0);
        islem(1'b0, TUR_W, 32'h8000_0008, 0, rv, rh, gec);
        kontrol("SB sonra LW", rv, 32'h1122_AA44);

        mem[4] = 32'h0;
        islem(1'b1, TUR_W, 32'h8000_0010, 32'h1234_5678, rv, rh, gec);
        kontrol("SW gecikme", 32'(gec), 32'd2);
        kontrol("SW bellek", mem[4], 32'h1234_5678);

        mem[511] = 32'hA5C3_0F81;
        islem(1'b0, TUR_W, 32'h8000_07FC, 0, rv, rh, gec);
        kontrol("son kelime LW", rv, 32'hA5C3_0F81);
        islem(1'b0, TUR_B, 32'h8000_07FF, 0, rv, rh, gec);
        kontrol("son bayt LB", rv, 32'hFFFF_FFA5);
        kontrol("son bayt hata", 32'(rh), 32'd0);

        yaz_sayisi = 0;
        islem(1'b0, TUR_H, 32'h8000_0001, 0, rv, rh, gec);
        kontrol("LH hizasiz hata", 32'(rh), 32'd1);
        kontrol("LH hizasiz veri", rv, 32'd0);
        kontrol("hata gecikme", 32'(gec), 32'd1);
        islem(1'b1, TUR_W, 32'h8000_0002, 32'hFFFF_FFFF, rv, rh, gec);
        kontrol("SW hizasiz hata", 32'(rh), 32'd1);
        islem(1'b0, TUR_W, 32'h7FFF_FFFC, 0, rv, rh, gec);
        kontrol("LW alt sinir hata", 32'(rh), 32'd1);
        islem(1'b0, TUR_W, 32'h8000_0800, 0, rv, rh, gec);
        kontrol("LW ust sinir hata", 32'(rh), 32'd1);
        kontrol("LW ust sinir veri", rv, 32'd0);
        islem(1'b0, 3'b011, 32'h8000_0000, 0, rv, rh, gec);
        kontrol("gecersiz tur hata", 32'(rh), 32'd1);
        islem(1'b1, TUR_BU, 32'h8000_0000, 32'h11, rv, rh, gec);
        kontrol("SBU hata", 32'(rh), 32'd1);
        kontrol("hatalarda yazma yok", 32'(yaz_sayisi), 32'd0);

        // SH with the response held off for 5 cycles.
        @(negedge clk);
        istek_gecerli = 1'b1; istek_yaz = 1'b1; istek_tur = TUR_H;
        istek_adres = 32'h8000_0012; istek_veri = 32'h0000_BEEF; yanit_hazir = 1'b0;
        @(posedge clk); #1;
        istek_gecerli = 1'b0;
        gec = -1;
        for (int k = 1; k <= 20; k++) begin
            if (yanit_gecerli) begin gec = k; break; end
            @(posedge clk); #1;
        end
        kontrol("SH gecikme", 32'(gec), 32'd3);
        for (int k = 0; k < 5; k++) begin
            kontrol("SH bekle gecerli", 32'(yanit_gecerli), 32'd1);
            kontrol("SH bekle veri", yanit_veri, 32'd0);
            kontrol("SH bekle istek_hazir", 32'(istek_hazir), 32'd0);
            @(posedge clk); #1;
        end
        yanit_hazir = 1'b1;
        @(posedge clk); #1;
        kontrol("SH sonra istek_hazir", 32'(istek_hazir), 32'd1);
        kontrol("SH bellek", mem[4], 32'hBEEF_5678);

        // Reset in the YAZ cycle of a word store.
        mem[5] = 32'h5555_5555;
        @(negedge clk);
        istek_gecerli = 1'b1; istek_yaz = 1'b1; istek_tur = TUR_W;
        istek_adres = 32'h8000_0014; istek_veri = 32'hCAFE_F00D;
        @(posedge clk); #1;
        istek_gecerli = 1'b0;
        kontrol("YAZ gecerli", 32'(bellek_yaz_gecerli), 32'd1);
        #2 rst_n = 1'b0;
        #1 kontrol("reset yaz_gecerli dusus", 32'(bellek_yaz_gecerli), 32'd0);
        @(posedge clk); #1;
        @(negedge clk) rst_n = 1'b1;
        #1;
        kontrol("reset sonra bellek", mem[5], 32'h5555_5555);
        kontrol("reset sonra istek_hazir", 32'(istek_hazir), 32'd1);
        kontrol("reset sonra yanit_gecerli", 32'(yanit_gecerli), 32'd0);

        islem(1'b0, TUR_W, 32'h8000_0014, 0, rv, rh, gec);
        kontrol("reset sonra LW", rv, 32'h5555_5555);

        $display("TB_RESULT checks=%0d failures=%0d", kontroller, hatalar);
        $finish;
    end

endmodule
